// File: rtl/booth_digit_decoder.sv
// booth_digit_decoder: rebuilds an N-bit two's-complement multiplier from its radix-16 Booth digit stream
// Optional macro BOOTH_DEC_OVF_CHECK_EN adds res_ovf_o (the final sum does not fit in N signed bits).
// Ports: clk, rst_n (async active-low), flush_i (sync abort),
//        dig_valid_i/dig_ready_o/dig_sel_i/dig_neg_i (digit stream, LSB digit first),
//        res_valid_o/res_ready_i/res_o[/res_ovf_o] (reconstructed multiplier).
package mul_pkg;
  typedef enum logic [3:0] {PP_0, PP_A, PP_2A, PP_3A, PP_4A, PP_5A, PP_6A, PP_7A, PP_8A} booth_sel_t;
endpackage

module booth_digit_decoder
  import mul_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         dig_valid_i,
  output logic         dig_ready_o,
  input  booth_sel_t   dig_sel_i,
  input  logic         dig_neg_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
`ifdef BOOTH_DEC_OVF_CHECK_EN
  output logic         res_ovf_o,
`endif
  output logic [N-1:0] res_o
);
  localparam int NDIG = N / 4;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
`ifdef BOOTH_DEC_OVF_CHECK_EN
  // one guard bit so an out-of-range digit sequence is still visible
  localparam int AW = N + 1;
`else
  localparam int AW = N;
`endif
  typedef enum logic {COLLECT, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic signed [AW-1:0] r_acc, w_dig, w_sum;
  logic [3:0] w_mag;
  logic [N-1:0] r_res;
  logic w_last, w_take, w_hs;
  always_comb begin
    case (dig_sel_i)
      PP_A:    w_mag = 4'd1;
      PP_2A:   w_mag = 4'd2;
      PP_3A:   w_mag = 4'd3;
      PP_4A:   w_mag = 4'd4;
      PP_5A:   w_mag = 4'd5;
      PP_6A:   w_mag = 4'd6;
      PP_7A:   w_mag = 4'd7;
      PP_8A:   w_mag = 4'd8;
      default: w_mag = 4'd0;
    endcase
  end
  assign w_dig = dig_neg_i ? -{{(AW-4){1'b0}}, w_mag} : {{(AW-4){1'b0}}, w_mag};
  // digit i carries weight 16^i
  assign w_sum = r_acc + (w_dig <<< {r_cnt, 2'b00});
  assign w_last = r_cnt == CW'(NDIG - 1);
  assign dig_ready_o = r_state == COLLECT;
  assign res_valid_o = r_state == DONE;
  assign w_take = dig_ready_o & dig_valid_i & ~flush_i;
  assign w_hs = res_valid_o & res_ready_i & ~flush_i;
  assign res_o = r_res;
  always_comb begin
    w_next = r_state;
    if (flush_i) w_next = COLLECT;
    else if (r_state == COLLECT) w_next = (dig_valid_i && w_last) ? DONE : COLLECT;
    else w_next = res_ready_i ? COLLECT : DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= COLLECT;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_res <= '0;
    end else if (flush_i || w_hs) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_res <= w_sum[N-1:0];
    end
  end
`ifdef BOOTH_DEC_OVF_CHECK_EN
  logic r_ovf;
  assign res_ovf_o = r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (flush_i || w_hs) r_ovf <= 1'b0;
    else if (w_take && w_last) r_ovf <= w_sum[N] ^ w_sum[N-1];
  end
`endif
endmodule

// File: tb/tb_booth_digit_decoder.sv
// tb_booth_digit_decoder: self-checking bench with a digit-list reference model for booth_digit_decoder
module tb_booth_digit_decoder;
  import mul_pkg::*;
  localparam int N = 16;
  localparam int NDIG = N / 4;
  logic clk = 0, rst_n = 0, flush = 0, dig_valid = 0, dig_neg = 0, res_ready = 0;
  booth_sel_t dig_sel = PP_0;
  logic dig_ready, res_valid;
  logic [N-1:0] res;
`ifdef BOOTH_DEC_OVF_CHECK_EN
  logic res_ovf;
`endif
  int checks = 0, failures = 0;
  bit rnd = 0;
  booth_digit_decoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .dig_valid_i(dig_valid), .dig_ready_o(dig_ready), .dig_sel_i(dig_sel), .dig_neg_i(dig_neg),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
`ifdef BOOTH_DEC_OVF_CHECK_EN
    .res_ovf_o(res_ovf),
`endif
    .res_o(res)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mag_of(input booth_sel_t s);
    case (s)
      PP_A: return 1;
      PP_2A: return 2;
      PP_3A: return 3;
      PP_4A: return 4;
      PP_5A: return 5;
      PP_6A: return 6;
      PP_7A: return 7;
      PP_8A: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic longint total(input int d[$]);
    longint s = 0;
    foreach (d[i]) s += longint'(d[i]) * (longint'(1) << (4 * i));
    return s;
  endfunction

  // reference model: a list of accepted digit values and the pending result
  int q[$];
  bit m_valid = 0, m_ovf = 0;
  logic [N-1:0] m_res = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_valid <= 0;
      m_ovf <= 0;
      m_res <= '0;
    end else if (flush) begin
      q.delete();
      m_valid <= 0;
      m_ovf <= 0;
    end else if (!m_valid) begin
      if (dig_valid) begin
        q.push_back(dig_neg ? -mag_of(dig_sel) : mag_of(dig_sel));
        if (q.size() == NDIG) begin
          m_res <= N'(total(q));
          m_ovf <= total(q) < -(longint'(1) << (N - 1)) || total(q) >= (longint'(1) << (N - 1));
          m_valid <= 1;
          q.delete();
        end
      end
    end else if (res_ready) begin
      m_valid <= 0;
      m_ovf <= 0;
    end
  end

  always @(negedge clk) begin
    chk("ready", dig_ready, !m_valid);
    chk("valid", res_valid, m_valid);
    if (m_valid) chk("res", res, m_res);
`ifdef BOOTH_DEC_OVF_CHECK_EN
    chk("ovf", res_ovf, m_ovf);
`endif
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input booth_sel_t s, input bit n);
    int k = 0;
    bit took;
    dig_sel = s;
    dig_neg = n;
    dig_valid = 1;
    do begin
      if (rnd) begin
        res_ready = $urandom_range(0, 1);
        flush = $urandom_range(0, 39) == 0;
      end
      took = dig_ready && !flush;
      cyc();
      k++;
    end while (!took && k < 50);
    if (!took) chk("send_timeout", 0, 1);
    dig_valid = 0;
    flush = 0;
  endtask

  task automatic op4(input booth_sel_t a, b, c, d, input bit [3:0] n);
    send(a, n[0]);
    send(b, n[1]);
    send(c, n[2]);
    send(d, n[3]);
  endtask

  task automatic expect_res(input string nm, input logic [N-1:0] r, input bit o);
    int k = 0;
    while (!res_valid && k < 20) begin
      cyc();
      k++;
    end
    chk({nm, "_valid"}, res_valid, 1);
    chk(nm, res, r);
`ifdef BOOTH_DEC_OVF_CHECK_EN
    chk({nm, "_ovf"}, res_ovf, o);
`else
    chk({nm, "_ovf_model"}, m_ovf, o);
`endif
    res_ready = 1;
    cyc();
    res_ready = 0;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"}, dig_ready, 1);
    chk({nm, "_valid"}, res_valid, 0);
    chk({nm, "_res"}, res, 0);
`ifdef BOOTH_DEC_OVF_CHECK_EN
    chk({nm, "_ovf"}, res_ovf, 0);
`endif
  endtask

  task automatic pulse_reset;
    @(posedge clk);
    #3 rst_n = 0;
    #1 check_reset_vals("async_rst");
    @(posedge clk);
    #3 rst_n = 1;
    cyc();
  endtask

  initial begin
    booth_sel_t sels[9] = '{PP_0, PP_A, PP_2A, PP_3A, PP_4A, PP_5A, PP_6A, PP_7A, PP_8A};
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    cyc();
    check_reset_vals("reset");
    op4(PP_4A, PP_3A, PP_2A, PP_A, 4'b0000);
    chk("latency", res_valid, 1);
    expect_res("r1234", 16'h1234, 0);
    op4(PP_A, PP_0, PP_0, PP_0, 4'b1111);
    expect_res("rminus1", 16'hFFFF, 0);
    op4(PP_0, PP_0, PP_0, PP_8A, 4'b1000);
    expect_res("r8000", 16'h8000, 0);
    op4(PP_8A, PP_8A, PP_8A, PP_8A, 4'b0000);
    expect_res("r8888", 16'h8888, 1);
    // backpressure with a digit waiting
    op4(PP_4A, PP_3A, PP_2A, PP_A, 4'b0000);
    dig_valid = 1;
    dig_sel = PP_5A;
    dig_neg = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", dig_ready, 0);
      chk("bp_res", res, 16'h1234);
      cyc();
    end
    res_ready = 1;
    cyc();
    res_ready = 0;
    dig_valid = 0;
    chk("bp_next_ready", dig_ready, 1);
    chk("bp_no_valid", res_valid, 0);
    op4(PP_7A, PP_0, PP_0, PP_0, 4'b0001);
    expect_res("rminus7", 16'hFFF9, 0);
    // flush after two digits, with a digit offered in the flush cycle
    send(PP_8A, 0);
    send(PP_8A, 0);
    flush = 1;
    dig_valid = 1;
    dig_sel = PP_3A;
    cyc();
    flush = 0;
    dig_valid = 0;
    chk("flush_valid", res_valid, 0);
    op4(PP_4A, PP_3A, PP_2A, PP_A, 4'b0000);
    expect_res("flush_r1234", 16'h1234, 0);
    // async reset in DONE and mid-operand
    op4(PP_8A, PP_8A, PP_8A, PP_8A, 4'b0000);
    pulse_reset();
    send(PP_5A, 1);
    send(PP_2A, 0);
    pulse_reset();
    op4(PP_4A, PP_3A, PP_2A, PP_A, 4'b0000);
    expect_res("rst_r1234", 16'h1234, 0);
    // randomized operands, gaps, backpressure and flushes
    rnd = 1;
    for (int t = 0; t < 40; t++) begin
      for (int d = 0; d < NDIG; d++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) cyc();
        send(sels[$urandom_range(0, 8)], 1'($urandom_range(0, 1)));
      end
    end
    rnd = 0;
    res_ready = 1;
    repeat (3) cyc();
    res_ready = 0;
    chk("drain_ready", dig_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
